// File: rtl/oram_functions_pkg.sv
// Shared types for the Path-ORAM controller: stash/bucket records, FSM states, path test.
// The record field widths follow the tree depth and block width fixed here.
package oram_functions_pkg;

  localparam int ORAM_TREE_DEPTH = 3;
  localparam int BYTE_WIDTH      = 8;
  localparam int BYTES_PER_BLOCK = 4;
  localparam int ORAM_BLOCK_W    = BYTE_WIDTH * BYTES_PER_BLOCK;
  localparam int LEVEL_W         = $clog2(ORAM_TREE_DEPTH + 1);

  typedef logic [ORAM_TREE_DEPTH-1:0] leaf_t;
  typedef logic [ORAM_TREE_DEPTH-1:0] id_t;
  typedef logic [ORAM_BLOCK_W-1:0]    data_t;
  typedef logic [LEVEL_W-1:0]         level_t;

  typedef struct packed {
    logic  valid;
    id_t   id;
    leaf_t leaf;
    data_t data;
  } stash_entry_t;

  typedef struct packed {
    logic  valid;
    id_t   id;
    leaf_t leaf;
    data_t data;
  } bucket_slot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_PATH,
    ST_UPDATE,
    ST_WRITE_PATH,
    ST_RESP
  } oram_state_t;

  // Two leaves share the bucket at `level` when their top `level` path bits agree.
  function automatic logic path_match(input leaf_t leaf_a, input leaf_t leaf_b,
                                      input level_t level);
    return (leaf_a >> (ORAM_TREE_DEPTH - int'(level))) ==
           (leaf_b >> (ORAM_TREE_DEPTH - int'(level)));
  endfunction

endpackage

// File: rtl/oram_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances one step per enabled cycle.
module oram_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SEED;
    end else if (enable) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/path_oram_ctrl.sv
// Path-ORAM controller: position map, bounded stash, greedy path eviction, valid/ready I/O.
// Defining ORAM_STASH_OCC_EN adds the stash_occ / stash_peak occupancy outputs.
import oram_functions_pkg::*;

module path_oram_ctrl #(
  parameter int          TREE_DEPTH = ORAM_TREE_DEPTH,
  parameter int          BUCKET_Z   = 4,
  parameter int          BLOCK_W    = ORAM_BLOCK_W,
  parameter int          STASH_SIZE = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  rw_indicator,
  input  logic [TREE_DEPTH-1:0] block_num,
  input  logic [BLOCK_W-1:0]    write_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_W-1:0]    read_val,
`ifdef ORAM_STASH_OCC_EN
  output logic [$clog2(STASH_SIZE+1)-1:0] stash_occ,
  output logic [$clog2(STASH_SIZE+1)-1:0] stash_peak,
`endif
  output logic                  stash_overflow
);

  localparam int LEAVES      = 2 ** TREE_DEPTH;
  localparam int NUM_BLOCKS  = 2 ** TREE_DEPTH;
  localparam int NUM_BUCKETS = (2 ** (TREE_DEPTH + 1)) - 1;
  localparam int BKT_W       = $clog2(NUM_BUCKETS);
  localparam level_t LAST_LEVEL = level_t'(TREE_DEPTH);

  oram_state_t  state, state_n;
  level_t       level, level_n;
  logic         rw_q;
  id_t          blk_q;
  data_t        wval_q, rv_q, rv_n;
  leaf_t        leaf_q;
  logic         out_valid_q, out_valid_n, ovf_q;
  data_t        read_val_q, read_val_n;

  leaf_t        pos   [NUM_BLOCKS];
  stash_entry_t stash [STASH_SIZE];
  stash_entry_t stash_n [STASH_SIZE];
  bucket_slot_t tree  [NUM_BUCKETS][BUCKET_Z];
  bucket_slot_t bucket_n [BUCKET_Z];
  logic [BKT_W-1:0] bidx;

  logic         bucket_we, pos_we, lfsr_en, ovf_set, accept;
  logic         hit, found;
  int           hidx, fidx, cnt;
  logic [15:0]  lfsr;
  leaf_t        new_leaf;
  logic [15-TREE_DEPTH:0] lfsr_unused;

  oram_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (lfsr_en),
    .state  (lfsr)
  );

  assign new_leaf    = lfsr[TREE_DEPTH-1:0];
  assign lfsr_unused = lfsr[15:TREE_DEPTH];

  // Heap-ordered tree: bucket on leaf's path at `level` is (2^level - 1) + leaf's top bits.
  always_comb begin
    bidx = BKT_W'((32'd1 << level) - 32'd1 + 32'(leaf_q >> (TREE_DEPTH - int'(level))));
  end

  assign in_ready       = rst && (state == ST_IDLE);
  assign accept         = (state == ST_IDLE) && in_valid;
  assign out_valid      = out_valid_q;
  assign read_val       = read_val_q;
  assign stash_overflow = ovf_q;

  always_comb begin
    state_n     = state;
    level_n     = level;
    stash_n     = stash;
    bucket_we   = 1'b0;
    pos_we      = 1'b0;
    lfsr_en     = 1'b0;
    ovf_set     = 1'b0;
    rv_n        = rv_q;
    out_valid_n = out_valid_q;
    read_val_n  = read_val_q;
    hit         = 1'b0;
    found       = 1'b0;
    hidx        = 0;
    fidx        = 0;
    cnt         = 0;
    for (int z = 0; z < BUCKET_Z; z++) bucket_n[z] = tree[bidx][z];

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_n = ST_READ_PATH;
          level_n = '0;
        end
      end

      ST_READ_PATH: begin
        bucket_we = 1'b1;
        for (int z = 0; z < BUCKET_Z; z++) begin
          if (tree[bidx][z].valid) begin
            found = 1'b0;
            for (int s = 0; s < STASH_SIZE; s++) begin
              if (!found && !stash_n[s].valid) begin
                stash_n[s] = stash_entry_t'(tree[bidx][z]);
                found      = 1'b1;
              end
            end
            if (!found) ovf_set = 1'b1;
            bucket_n[z].valid = 1'b0;
          end
        end
        if (level == LAST_LEVEL) state_n = ST_UPDATE;
        else                     level_n = level + 1'b1;
      end

      ST_UPDATE: begin
        for (int s = 0; s < STASH_SIZE; s++) begin
          if (!hit && stash[s].valid && stash[s].id == blk_q) begin
            hit  = 1'b1;
            hidx = s;
          end
        end
        rv_n = hit ? stash[hidx].data : '0;
        if (hit) begin
          stash_n[hidx].leaf = new_leaf;
          if (rw_q) stash_n[hidx].data = wval_q;
        end else if (rw_q) begin
          for (int s = 0; s < STASH_SIZE; s++) begin
            if (!found && !stash[s].valid) begin
              found = 1'b1;
              fidx  = s;
            end
          end
          if (found) begin
            stash_n[fidx].valid = 1'b1;
            stash_n[fidx].id    = blk_q;
            stash_n[fidx].leaf  = new_leaf;
            stash_n[fidx].data  = wval_q;
          end else begin
            ovf_set = 1'b1;
          end
        end
        pos_we  = 1'b1;
        lfsr_en = 1'b1;
        level_n = LAST_LEVEL;
        state_n = ST_WRITE_PATH;
      end

      ST_WRITE_PATH: begin
        // Eviction walks the path that was just read, deepest bucket first.
        bucket_we = 1'b1;
        for (int z = 0; z < BUCKET_Z; z++) bucket_n[z] = '0;
        for (int s = 0; s < STASH_SIZE; s++) begin
          if (cnt < BUCKET_Z && stash[s].valid && path_match(stash[s].leaf, leaf_q, level)) begin
            bucket_n[cnt]    = bucket_slot_t'(stash[s]);
            stash_n[s].valid = 1'b0;
            cnt              = cnt + 1;
          end
        end
        if (level == '0) state_n = ST_RESP;
        else             level_n = level - 1'b1;
      end

      ST_RESP: begin
        if (out_valid_q && out_ready) begin
          out_valid_n = 1'b0;
          read_val_n  = '0;
          state_n     = ST_IDLE;
        end else begin
          out_valid_n = 1'b1;
          read_val_n  = rv_q;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      level       <= '0;
      rw_q        <= 1'b0;
      blk_q       <= '0;
      wval_q      <= '0;
      leaf_q      <= '0;
      rv_q        <= '0;
      out_valid_q <= 1'b0;
      read_val_q  <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) pos[i] <= leaf_t'(i % LEAVES);
      for (int s = 0; s < STASH_SIZE; s++) stash[s] <= '0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      rv_q        <= rv_n;
      out_valid_q <= out_valid_n;
      read_val_q  <= read_val_n;
      ovf_q       <= ovf_q | ovf_set;
      stash       <= stash_n;
      if (accept) begin
        rw_q   <= rw_indicator;
        blk_q  <= block_num;
        wval_q <= write_val;
        leaf_q <= pos[block_num];
      end
      if (pos_we) pos[blk_q] <= new_leaf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BUCKETS; b++)
        for (int z = 0; z < BUCKET_Z; z++) tree[b][z].valid <= 1'b0;
    end else if (bucket_we) begin
      for (int z = 0; z < BUCKET_Z; z++) tree[bidx][z] <= bucket_n[z];
    end
  end

`ifdef ORAM_STASH_OCC_EN
  localparam int OCC_W = $clog2(STASH_SIZE + 1);
  logic [OCC_W-1:0] occ;

  always_comb begin
    occ = '0;
    for (int s = 0; s < STASH_SIZE; s++) occ = occ + OCC_W'(stash[s].valid);
  end

  always_ff @(posedge clk) begin
    if (!rst)             stash_peak <= '0;
    else if (occ > stash_peak) stash_peak <= occ;
  end

  assign stash_occ = occ;
`endif

endmodule

// File: tb/tb_path_oram_ctrl.sv
// Bench for path_oram_ctrl: vector table, handshake/reset corner sequences, random scoreboard run.
module tb_path_oram_ctrl;

  localparam int D   = 3;
  localparam int Z   = 4;
  localparam int W   = 32;
  localparam int SS  = Z * (D + 1) + 2;
  localparam int LAT = 2 * D + 4;
  localparam int NB  = 2 ** D;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         rw_indicator;
  logic [D-1:0] block_num;
  logic [W-1:0] write_val;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] read_val;
  logic         stash_overflow;
`ifdef ORAM_STASH_OCC_EN
  logic [$clog2(SS+1)-1:0] stash_occ;
  logic [$clog2(SS+1)-1:0] stash_peak;
`endif

  always #5 clk = ~clk;

  path_oram_ctrl #(
    .TREE_DEPTH (D),
    .BUCKET_Z   (Z),
    .BLOCK_W    (W),
    .STASH_SIZE (SS),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rw_indicator   (rw_indicator),
    .block_num      (block_num),
    .write_val      (write_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .read_val       (read_val),
`ifdef ORAM_STASH_OCC_EN
    .stash_occ      (stash_occ),
    .stash_peak     (stash_peak),
`endif
    .stash_overflow (stash_overflow)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem [NB];

  typedef struct {
    logic         rw;
    logic [D-1:0] blk;
    logic [W-1:0] val;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference memory: a read returns the last written value, writes return the old one.
  function automatic logic [W-1:0] model_access(input logic rw, input logic [D-1:0] blk,
                                                input logic [W-1:0] val);
    logic [W-1:0] old;
    old = model_mem[blk];
    if (rw) model_mem[blk] = val;
    return old;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) model_mem[i] = '0;
  endfunction

  task automatic issue(input logic rw, input logic [D-1:0] blk, input logic [W-1:0] val);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid     = 1'b1;
    rw_indicator = rw;
    block_num    = blk;
    write_val    = val;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic access(input logic rw, input logic [D-1:0] blk, input logic [W-1:0] val,
                        output logic [W-1:0] rv, output int lat);
    issue(rw, blk, val);
    wait_resp(lat);
    rv = read_val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rv;
    logic [W-1:0] held;
    int lat;

    vecs[0] = '{rw: 1'b1, blk: 3'd1, val: 32'd2, exp: 32'd0};
    vecs[1] = '{rw: 1'b0, blk: 3'd1, val: 32'd0, exp: 32'd2};
    for (int i = 0; i < 8; i++)
      vecs[2 + i] = '{rw: 1'b1, blk: 3'(i), val: 32'(10 + i), exp: (i == 1) ? 32'd2 : 32'd0};
    for (int j = 0; j < 8; j++)
      vecs[10 + j] = '{rw: 1'b0, blk: 3'(7 - j), val: 32'd0, exp: 32'(10 + 7 - j)};
    vecs[18] = '{rw: 1'b1, blk: 3'd3, val: 32'd10, exp: 32'd13};
    vecs[19] = '{rw: 1'b1, blk: 3'd3, val: 32'd11, exp: 32'd10};
    vecs[20] = '{rw: 1'b0, blk: 3'd3, val: 32'd0, exp: 32'd11};

    rst = 1'b0; in_valid = 1'b0; rw_indicator = 1'b0; block_num = '0;
    write_val = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_read_val", read_val, 0);
    check("reset_overflow", stash_overflow, 0);
    @(negedge clk) rst = 1'b1;
    #1 check("idle_in_ready", in_ready, 1);

    for (int k = 0; k < 21; k++) begin
      void'(model_access(vecs[k].rw, vecs[k].blk, vecs[k].val));
      access(vecs[k].rw, vecs[k].blk, vecs[k].val, rv, lat);
      check($sformatf("vec%0d_read_val", k), rv, vecs[k].exp);
      if (k < 2) check($sformatf("vec%0d_latency", k), lat, LAT);
    end
    check("table_overflow", stash_overflow, 0);

    // Response stall: outputs hold, in_ready stays low, stray requests are dropped.
    out_ready = 1'b0;
    issue(1'b0, 3'd3, '0);
    wait_resp(lat);
    check("stall_latency", lat, LAT);
    held = read_val;
    check("stall_first_val", held, 32'd11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; rw_indicator = 1'b1; block_num = 3'd3; write_val = 32'd99;
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_out_valid", i), out_valid, 1);
      check($sformatf("stall%0d_read_val", i), read_val, held);
      check($sformatf("stall%0d_in_ready", i), in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("stall_release_out_valid", out_valid, 0);
    access(1'b0, 3'd3, '0, rv, lat);
    check("stall_ignored_write", rv, 32'd11);

    // Reset in the middle of path write-back.
    issue(1'b1, 3'd2, 32'd5);
    repeat (D + 3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_read_val", read_val, 0);
    check("midreset_in_ready", in_ready, 0);
    check("midreset_overflow", stash_overflow, 0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    access(1'b0, 3'd2, '0, rv, lat);
    check("midreset_blk2", rv, 0);
    access(1'b0, 3'd3, '0, rv, lat);
    check("midreset_blk3", rv, 0);

    for (int n = 0; n < 200; n++) begin
      logic         rw;
      logic [D-1:0] blk;
      logic [W-1:0] val;
      rw  = 1'($urandom_range(0, 1));
      blk = 3'($urandom_range(0, NB - 1));
      val = $urandom;
      exp_q.push_back(model_access(rw, blk, val));
      access(rw, blk, val, rv, lat);
      check($sformatf("rand%0d_read_val", n), rv, exp_q.pop_front());
      check($sformatf("rand%0d_latency", n), lat, LAT);
    end
    check("final_overflow", stash_overflow, 0);
`ifdef ORAM_STASH_OCC_EN
    check("stash_peak_bound", (stash_peak <= SS), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
